// File: rtl/nibble_serial_adder_pkg.sv
// nsa_pkg: shared nibble width and FSM state encoding for nibble_serial_adder
package nsa_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/nibble_serial_adder_cla.sv
// cla: 4-bit carry-lookahead adder, exposes the full carry vector C[4:0]
module cla (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CI,
  output logic [3:0] S,
  output logic [4:0] C
);
  logic [3:0] w_g, w_p;
  assign w_g = A & B;
  assign w_p = A ^ B;
  assign C[0] = CI;
  assign C[1] = w_g[0] | (w_p[0] & CI);
  assign C[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & CI);
  assign C[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & CI);
  assign C[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0]) | (&w_p & CI);
  assign S = w_p ^ C[3:0];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add through one 4-bit CLA, one nibble per cycle LSB first; OVERFLOW_FLAG_EN enables ovf
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = $clog2(NIB + 1);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_c, r_cout, w_last;
  logic [3:0]       w_s;
  logic [4:0]       w_c;
  logic [3:0]       w_unused_c;
  cla u_cla (.A(r_a[3:0]), .B(r_b[3:0]), .CI(r_c), .S(w_s), .C(w_c));
  assign w_unused_c = w_c[3:0];
  assign w_last     = r_cnt == CW'(NIB - 1);
  assign in_ready   = r_state == IDLE;
  assign out_valid  = r_state == DONE;
  assign busy       = r_state != IDLE;
  assign sum        = r_sum;
  assign cout       = r_cout;
  always_comb begin
    w_next = (r_state == IDLE && in_valid) ? RUN :
             (r_state == RUN && w_last)    ? DONE :
             (r_state == DONE && out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // sum bits enter at the top so the LSB nibble lands at bit 0 after NIB shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a   <= a;
      r_b   <= b;
      r_c   <= cin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> NIBBLE_W;
      r_b   <= r_b >> NIBBLE_W;
      r_sum <= (r_sum >> NIBBLE_W) | (WIDTH'(w_s) << (WIDTH - NIBBLE_W));
      r_c   <= w_c[4];
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_cout <= w_c[4];
    end
  end
`ifdef OVERFLOW_FLAG_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= w_c[4] ^ w_c[3];
  end
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif
endmodule
